perceptron_train_ctrl: RTL

PERCEPTRON_TRAIN_CTRL -- requirements
Module: perceptron_train_ctrl

---
 rtl/perceptron_train_ctrl.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/perceptron_train_ctrl.sv
// -----------------------------------------------------------------------------
// perceptron_train_ctrl
//
// Control FSM for perceptron training. It walks a sample memory of N entries
// once per epoch. For each sample it fetches the sample, latches it into the
// datapath, evaluates the output and checks it against the target. On a
// mismatch it applies one weight/bias update. Training stops when a whole
// epoch completes with no mismatches (converged) or when E epochs have run.
//
// Ports
//   clk        : clock; all state updates on the rising edge
//   rst        : synchronous active-high reset
//   start      : one-cycle training request, accepted in IDLE or DONE only
//   nBus       : sample count N, latched when start is accepted
//   maxEpoch   : epoch limit E, latched when start is accepted (0 = 256)
//   mismatch   : datapath compare result, looked at in CHECK only
//   addr       : sample memory address (current sample index)
//   memRd      : sample memory read strobe (FETCH)
//   initW      : clear weights and bias (INIT)
//   ldX        : latch X1, X2 and t from memory (LATCH)
//   eval       : compute y (EVAL)
//   ldW        : apply weight/bias update (UPDATE)
//   busy       : high in every state except IDLE and DONE
//   done       : high in DONE until the next accepted start or reset
//   converged  : valid with done; 1 = final epoch had no mismatches
//   epochCount : epochs completed in the current run
// -----------------------------------------------------------------------------
module perceptron_train_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [5:0] nBus,
    input  logic [7:0] maxEpoch,
    input  logic       mismatch,
    output logic [5:0] addr,
    output logic       memRd,
    output logic       initW,
    output logic       ldX,
    output logic       eval,
    output logic       ldW,
    output logic       busy,
    output logic       done,
    output logic       converged,
    output logic [8:0] epochCount
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_INIT,
        S_FETCH,
        S_LATCH,
        S_EVAL,
        S_CHECK,
        S_UPDATE,
        S_NEXT,
        S_DONE
    } state_t;

    state_t     state_reg, state_next;
    logic [5:0] idx_reg, idx_next;
    logic [5:0] n_reg, n_next;
    logic [7:0] e_reg, e_next;
    logic       err_reg, err_next;
    logic [8:0] epoch_reg, epoch_next;
    logic       done_reg, done_next;
    logic       conv_reg, conv_next;

    logic       mem_rd_reg, init_w_reg, ld_x_reg, eval_reg, ld_w_reg, busy_reg;

    // An epoch limit of 0 stands for 256 epochs, which needs the 9th bit.
    logic [8:0] epoch_limit;
    logic [8:0] epoch_inc;
    logic [5:0] last_idx;

    assign epoch_limit = (e_reg == 8'd0) ? 9'd256 : {1'b0, e_reg};
    assign epoch_inc   = epoch_reg + 9'd1;
    assign last_idx    = n_reg - 6'd1;

    // Next-state and datapath-register logic.
    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        n_next     = n_reg;
        e_next     = e_reg;
        err_next   = err_reg;
        epoch_next = epoch_reg;
        done_next  = done_reg;
        conv_next  = conv_reg;

        case (state_reg)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_next = S_INIT;
                    n_next     = nBus;
                    e_next     = maxEpoch;
                    idx_next   = 6'd0;
                    err_next   = 1'b0;
                    epoch_next = 9'd0;
                    done_next  = 1'b0;
                    conv_next  = 1'b0;
                end
            end
            S_INIT: begin
                if (n_reg != 6'd0) begin
                    state_next = S_FETCH;
                end else begin
                    // An empty training set is trivially converged.
                    state_next = S_DONE;
                    done_next  = 1'b1;
                    conv_next  = 1'b1;
                end
            end
            S_FETCH:  state_next = S_LATCH;
            S_LATCH:  state_next = S_EVAL;
            S_EVAL:   state_next = S_CHECK;
            S_CHECK: begin
                if (mismatch) begin
                    state_next = S_UPDATE;
                    err_next   = 1'b1;
                end else begin
                    state_next = S_NEXT;
                end
            end
            S_UPDATE: state_next = S_NEXT;
            S_NEXT: begin
                if (idx_reg != last_idx) begin
                    idx_next   = idx_reg + 6'd1;
                    state_next = S_FETCH;
                end else begin
                    epoch_next = epoch_inc;
                    if (!err_reg) begin
                        state_next = S_DONE;
                        done_next  = 1'b1;
                        conv_next  = 1'b1;
                    end else if (epoch_inc == epoch_limit) begin
                        state_next = S_DONE;
                        done_next  = 1'b1;
                        conv_next  = 1'b0;
                    end else begin
                        idx_next   = 6'd0;
                        err_next   = 1'b0;
                        state_next = S_FETCH;
                    end
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // State register; strobes are decoded from the next state so that each
    // one is registered and high exactly while the FSM sits in its state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= S_IDLE;
            idx_reg    <= 6'd0;
            n_reg      <= 6'd0;
            e_reg      <= 8'd0;
            err_reg    <= 1'b0;
            epoch_reg  <= 9'd0;
            done_reg   <= 1'b0;
            conv_reg   <= 1'b0;
            mem_rd_reg <= 1'b0;
            init_w_reg <= 1'b0;
            ld_x_reg   <= 1'b0;
            eval_reg   <= 1'b0;
            ld_w_reg   <= 1'b0;
            busy_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            idx_reg    <= idx_next;
            n_reg      <= n_next;
            e_reg      <= e_next;
            err_reg    <= err_next;
            epoch_reg  <= epoch_next;
            done_reg   <= done_next;
            conv_reg   <= conv_next;
            mem_rd_reg <= (state_next == S_FETCH);
            init_w_reg <= (state_next == S_INIT);
            ld_x_reg   <= (state_next == S_LATCH);
            eval_reg   <= (state_next == S_EVAL);
            ld_w_reg   <= (state_next == S_UPDATE);
            busy_reg   <= (state_next != S_IDLE) && (state_next != S_DONE);
        end
    end

    assign addr       = idx_reg;
    assign memRd      = mem_rd_reg;
    assign initW      = init_w_reg;
    assign ldX        = ld_x_reg;
    assign eval       = eval_reg;
    assign ldW        = ld_w_reg;
    assign busy       = busy_reg;
    assign done       = done_reg;
    assign converged  = conv_reg;
    assign epochCount = epoch_reg;

endmodule
